// File: rtl/snes_pkg.sv
// Shared SNES controller definitions: button bit positions, frame constants and
// the reader state encoding. Also imported by snes_encoder.
package snes_pkg;

  localparam int SNES_BITS = 16;
  localparam logic [SNES_BITS-1:0] ID_MASK = 16'hF000;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    BIT_HIGH = 3'd2,
    BIT_LOW  = 3'd3,
    DONE     = 3'd4
  } snes_state_e;

endpackage

// File: rtl/snes_controller_reader_if.sv
// Pad-side serial lines plus the decoded button result of the SNES reader.
// master = the reader, slave = pad and downstream input multiplexer.
interface snes_controller_reader_if;
  import snes_pkg::*;

  logic                 enable;
  logic                 snes_data_i;
  logic                 snes_latch_o;
  logic                 snes_clk_o;
  logic [SNES_BITS-1:0] buttons;
  logic                 valid;
  logic                 present;

  modport master (
    input  enable, snes_data_i,
    output snes_latch_o, snes_clk_o, buttons, valid, present
  );

  modport slave (
    output enable, snes_data_i,
    input  snes_latch_o, snes_clk_o, buttons, valid, present
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit or bus inputs
// (SNES data, IR receiver, keyboard line).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments keep these as two distinct flops; blocking
  // would let q see d in the same edge and remove the metastability stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snes_controller_reader.sv
// Polling master for a physical SNES pad: issues latch/clock pulses every poll
// interval, shifts in 16 serial bits and publishes them as active-high buttons.
module snes_controller_reader
  import snes_pkg::*;
#(
  parameter int LATCH_CYCLES = 12,
  parameter int HALF_CYCLES  = 6,
  parameter int POLL_CYCLES  = 16667
) (
  input  logic                      clock,
  input  logic                      reset_n,
  snes_controller_reader_if.master  bus
);

  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W     = $clog2(PHASE_MAX + 1);
  localparam int POLL_W    = $clog2(POLL_CYCLES);
  localparam int IDX_W     = $clog2(SNES_BITS);

  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(SNES_BITS - 1);

  // A full frame must fit inside one poll interval, otherwise starts are skipped.
  if (POLL_CYCLES <= LATCH_CYCLES + 2 * SNES_BITS * HALF_CYCLES + 1) begin : g_bad_poll
    $error("POLL_CYCLES too short for one complete SNES frame");
  end

  snes_state_e          state;
  logic [POLL_W-1:0]    poll_cnt;
  logic [CNT_W-1:0]     phase_cnt;
  logic [IDX_W-1:0]     idx;
  logic [SNES_BITS-1:0] raw;
  logic                 data_sync;
  logic                 latch_q;
  logic                 sclk_q;
  logic [SNES_BITS-1:0] buttons_q;
  logic                 valid_q;
  logic                 present_q;

  sync_2ff #(.WIDTH(1)) u_data_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.snes_data_i),
    .q       (data_sync)
  );

  // Free-running frame timer; frame activity never disturbs it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
    end else if (poll_cnt == POLL_LAST) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + POLL_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      idx       <= '0;
      raw       <= '0;
      latch_q   <= 1'b0;
      sclk_q    <= 1'b1;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      present_q <= 1'b0;
    end else begin
      // NOTE: default-low here makes valid a single-cycle pulse without needing
      // an explicit clear in every state branch.
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (poll_cnt == POLL_LAST && bus.enable) begin
            state     <= LATCH;
            phase_cnt <= '0;
            latch_q   <= 1'b1;
          end
        end
        LATCH: begin
          if (phase_cnt == LATCH_LAST) begin
            state     <= BIT_HIGH;
            phase_cnt <= '0;
            idx       <= '0;
            latch_q   <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        BIT_HIGH: begin
          // Sample at the end of the high phase, when the pad output has long settled.
          if (phase_cnt == HALF_LAST) begin
            raw[idx]  <= data_sync;
            state     <= BIT_LOW;
            phase_cnt <= '0;
            sclk_q    <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        BIT_LOW: begin
          if (phase_cnt == HALF_LAST) begin
            sclk_q    <= 1'b1;
            phase_cnt <= '0;
            if (idx == IDX_LAST) begin
              // Publish on entry to DONE so buttons, present and valid align.
              state     <= DONE;
              buttons_q <= ~raw;
              present_q <= ((raw & ID_MASK) == ID_MASK);
              valid_q   <= 1'b1;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= BIT_HIGH;
            end
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.snes_latch_o = latch_q;
  assign bus.snes_clk_o   = sclk_q;
  assign bus.buttons      = buttons_q;
  assign bus.valid        = valid_q;
  assign bus.present      = present_q;

endmodule

// File: tb/tb_snes_controller_reader.sv
// Directed bench for snes_controller_reader with a behavioural pad model
// (parallel load on latch, shift on clock rise); short poll interval of 300.
module tb_snes_controller_reader;

  localparam int LATCH = 12;
  localparam int HALF  = 6;
  localparam int POLL  = 300;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  snes_controller_reader_if bus ();

  snes_controller_reader #(
    .LATCH_CYCLES (LATCH),
    .HALF_CYCLES  (HALF),
    .POLL_CYCLES  (POLL)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Pad model: raw word, bit0 first, 0 = pressed.
  logic [15:0] pad_word  = 16'hFFFF;
  logic [15:0] pad_sr    = 16'hFFFF;
  logic        unplugged = 1'b0;

  always @(posedge bus.snes_clk_o or posedge bus.snes_latch_o) begin
    if (bus.snes_latch_o) pad_sr <= pad_word;
    else                  pad_sr <= {1'b1, pad_sr[15:1]};
  end

  assign bus.snes_data_i = unplugged ? 1'b0 : pad_sr[0];

  // Cycle counter and negedge monitor of the pad-side waveforms.
  int   cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic latch_prev = 1'b0;
  logic clk_prev   = 1'b1;
  int   n_latch_rise = 0, latch_rise_cyc = 0, latch_width = 0;
  int   n_clk_fall = 0, clk_fall_cyc = 0, n_clk_bad = 0;
  int   n_valid = 0, valid_cyc = 0;

  always @(negedge clock) begin
    latch_prev <= bus.snes_latch_o;
    clk_prev   <= bus.snes_clk_o;
    if (bus.snes_latch_o && !latch_prev) begin
      n_latch_rise   <= n_latch_rise + 1;
      latch_rise_cyc <= cyc;
    end
    if (!bus.snes_latch_o && latch_prev) latch_width <= cyc - latch_rise_cyc;
    if (!bus.snes_clk_o && clk_prev) begin
      n_clk_fall   <= n_clk_fall + 1;
      clk_fall_cyc <= cyc;
    end
    if (bus.snes_clk_o && !clk_prev && (cyc - clk_fall_cyc) != HALF) n_clk_bad <= n_clk_bad + 1;
    if (bus.valid) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_latch(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (bus.snes_latch_o && n_latch_rise > 0 && latch_rise_cyc == cyc) ok = 1'b1;
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (bus.valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    int rel;
    reset_n   = 1'b0;
    bus.enable = 1'b1;
    pad_word  = 16'hFFF6;
    repeat (3) step();
    checks++; if (bus.snes_latch_o !== 1'b0) begin failures++; $display("FAIL reset_latch got=%b exp=0", bus.snes_latch_o); end
    checks++; if (bus.snes_clk_o !== 1'b1) begin failures++; $display("FAIL reset_clk got=%b exp=1", bus.snes_clk_o); end
    checks++; if (bus.buttons !== 16'h0000) begin failures++; $display("FAIL reset_buttons got=%h exp=0000", bus.buttons); end
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
    checks++; if (bus.present !== 1'b0) begin failures++; $display("FAIL reset_present got=%b exp=0", bus.present); end
    reset_n = 1'b1;
    rel = cyc;
    wait_latch(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL first_latch timeout"); end
    checks++; if (latch_rise_cyc - rel != POLL) begin failures++; $display("FAIL first_latch_delay got=%0d exp=%0d", latch_rise_cyc - rel, POLL); end
  endtask

  task automatic test_frame();
    bit ok;
    int f0 = n_clk_fall;
    int b0 = n_clk_bad;
    int rise = latch_rise_cyc;
    wait_valid(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL frame_valid timeout"); end
    checks++; if (latch_width != LATCH) begin failures++; $display("FAIL latch_width got=%0d exp=%0d", latch_width, LATCH); end
    checks++; if (n_clk_fall - f0 != 16) begin failures++; $display("FAIL clk_pulses got=%0d exp=16", n_clk_fall - f0); end
    checks++; if (n_clk_bad != b0) begin failures++; $display("FAIL clk_low_width bad=%0d exp=0", n_clk_bad - b0); end
    checks++; if (valid_cyc - rise != 204) begin failures++; $display("FAIL valid_latency got=%0d exp=204", valid_cyc - rise); end
    checks++; if (bus.buttons !== 16'h0009) begin failures++; $display("FAIL frame_buttons got=%h exp=0009", bus.buttons); end
    checks++; if (bus.present !== 1'b1) begin failures++; $display("FAIL frame_present got=%b exp=1", bus.present); end
    step();
    checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL valid_single got=%b exp=0", bus.valid); end
  endtask

  task automatic test_enable_gate();
    int l0 = n_latch_rise;
    int f0 = n_clk_fall;
    int v0 = n_valid;
    bus.enable = 1'b0;
    repeat (3 * POLL) step();
    checks++; if (n_latch_rise != l0) begin failures++; $display("FAIL disabled_latch got=%0d exp=0", n_latch_rise - l0); end
    checks++; if (n_clk_fall != f0) begin failures++; $display("FAIL disabled_clk got=%0d exp=0", n_clk_fall - f0); end
    checks++; if (n_valid != v0) begin failures++; $display("FAIL disabled_valid got=%0d exp=0", n_valid - v0); end
    checks++; if (bus.buttons !== 16'h0009) begin failures++; $display("FAIL disabled_hold got=%h exp=0009", bus.buttons); end
    bus.enable = 1'b1;
  endtask

  task automatic test_unplugged();
    bit ok;
    int v0;
    unplugged = 1'b1;
    wait_valid(700, ok);
    checks++; if (!ok) begin failures++; $display("FAIL unplugged_valid timeout"); end
    checks++; if (bus.buttons !== 16'hFFFF) begin failures++; $display("FAIL unplugged_buttons got=%h exp=FFFF", bus.buttons); end
    checks++; if (bus.present !== 1'b0) begin failures++; $display("FAIL unplugged_present got=%b exp=0", bus.present); end
    v0 = n_valid;
    repeat (POLL + 1) step();
    checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL unplugged_rate got=%0d exp=1", n_valid - v0); end
    unplugged = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int f0, v0, rel, rise;
    pad_word = 16'hFFEF;
    wait_latch(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midreset_latch timeout"); end
    f0 = n_clk_fall;
    repeat (LATCH + 7 * 2 * HALF + 3) step();
    checks++; if (n_clk_fall - f0 != 7) begin failures++; $display("FAIL midreset_position got=%0d exp=7", n_clk_fall - f0); end
    v0 = n_valid;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.snes_latch_o !== 1'b0 || bus.snes_clk_o !== 1'b1) begin failures++; $display("FAIL midreset_lines got=%b%b exp=01", bus.snes_latch_o, bus.snes_clk_o); end
    checks++; if (bus.buttons !== 16'h0000 || bus.present !== 1'b0) begin failures++; $display("FAIL midreset_outputs got=%h/%b exp=0000/0", bus.buttons, bus.present); end
    repeat (3) step();
    reset_n = 1'b1;
    rel = cyc;
    wait_latch(400, ok);
    checks++; if (!ok || latch_rise_cyc - rel != POLL) begin failures++; $display("FAIL midreset_restart got=%0d exp=%0d", latch_rise_cyc - rel, POLL); end
    checks++; if (n_valid != v0) begin failures++; $display("FAIL midreset_partial got=%0d exp=0", n_valid - v0); end
    rise = latch_rise_cyc;
    f0 = n_clk_fall;
    wait_valid(400, ok);
    checks++; if (!ok || valid_cyc - rise != 204) begin failures++; $display("FAIL midreset_latency got=%0d exp=204", valid_cyc - rise); end
    checks++; if (n_clk_fall - f0 != 16) begin failures++; $display("FAIL midreset_pulses got=%0d exp=16", n_clk_fall - f0); end
    checks++; if (bus.buttons !== 16'h0010 || bus.present !== 1'b1) begin failures++; $display("FAIL midreset_word got=%h/%b exp=0010/1", bus.buttons, bus.present); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int vc1, v0;
    pad_word = 16'hFEFF;
    wait_valid(400, ok);
    checks++; if (!ok || bus.buttons !== 16'h0100) begin failures++; $display("FAIL b2b_a got=%h exp=0100", bus.buttons); end
    vc1 = valid_cyc;
    v0  = n_valid;
    pad_word = 16'hF7FF;
    wait_valid(400, ok);
    checks++; if (!ok || bus.buttons !== 16'h0800) begin failures++; $display("FAIL b2b_r got=%h exp=0800", bus.buttons); end
    checks++; if (bus.present !== 1'b1) begin failures++; $display("FAIL b2b_present got=%b exp=1", bus.present); end
    checks++; if (valid_cyc - vc1 != POLL) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", valid_cyc - vc1, POLL); end
    checks++; if (n_valid - v0 != 1) begin failures++; $display("FAIL b2b_count got=%0d exp=1", n_valid - v0); end
  endtask

  initial begin
    bus.enable = 1'b0;
    test_reset();
    test_frame();
    test_enable_gate();
    test_unplugged();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snes_controller_reader.md
Name: snes_controller_reader

Overview:
- Polling master for a physical SNES controller, the console-side counterpart of the existing snes_encoder.
- Generates the latch and clock pulses and shifts in the controller's 16-bit serial word.
- Publishes the result as active-high button bits, so a real pad can feed the input multiplexer alongside the keyboard, IR and button-board paths.
- Runs from the 1 MHz divided clock; all timing parameters are in clock cycles.

Parameters:
LATCH_CYCLES, 12, latch high width (12 us at 1 MHz)
HALF_CYCLES, 6, SNES clock half-period (6 us)
POLL_CYCLES, 16667, frame start interval (~60 Hz); elaboration assertion: POLL_CYCLES > LATCH_CYCLES + 32*HALF_CYCLES + 1

Ports:
clock  input  1  system clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  polling enable, sampled only at frame start
snes_data_i  input  1  serial data from controller; asynchronous; active-low (0 = pressed)
snes_latch_o  output  1  latch to controller, active-high
snes_clk_o  output  1  clock to controller, idles high
buttons  output  16  last frame, inverted: bit0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 15:12 ID bits
valid  output  1  one-cycle pulse when buttons updates
present  output  1  controller detected in last frame

Behaviour:
- Reset values (async, immediate): snes_latch_o=0, snes_clk_o=1, buttons=0, valid=0, present=0, poll_cnt=0, state=IDLE, bit index=0, shift register=0.
- All outputs are registered.
- snes_data_i passes through a 2-flop synchronizer before use.
- poll_cnt is free-running from 0 to POLL_CYCLES-1, then wraps. It is never reset by frame activity.
- IDLE: when poll_cnt==POLL_CYCLES-1 and enable=1, go to LATCH on the next edge. With enable=0 no frame starts and buttons/present hold. The first frame therefore starts POLL_CYCLES cycles after reset release.
- LATCH: snes_latch_o=1, snes_clk_o=1 for exactly LATCH_CYCLES cycles, then go to BIT_HIGH with idx=0.
- BIT_HIGH: latch=0, clk=1 for HALF_CYCLES cycles. On the last cycle, the synchronized data is captured into raw[idx]. Then go to BIT_LOW.
- BIT_LOW: clk=0 for HALF_CYCLES cycles. On exit, if idx<15 then idx++ and go to BIT_HIGH; else go to DONE. The controller shifts on the clk rising edge at BIT_LOW→BIT_HIGH.
- DONE (1 cycle): buttons<=~raw; present<=(raw[15:12]==4'hF); valid=1 for exactly this cycle; then IDLE.
- Frame timing: exactly 16 clk low pulses of HALF_CYCLES each. valid asserts LATCH_CYCLES+32*HALF_CYCLES cycles after latch rises (204 with defaults).
- An unplugged pad with a pull-down reads raw=0, giving buttons=16'hFFFF and present=0. The result is still published with valid; downstream gates on present.
- enable deasserted mid-frame: the frame completes normally.
- Reset mid-frame: the frame is abandoned, outputs return to reset values immediately, and no partial update is published.
- A poll_cnt wrap during a frame has no effect; the next start is checked only in IDLE.

Decomposition:
- Package snes_pkg:
  - button index constants (BTN_B=0 … BTN_R=11)
  - state enum {IDLE, LATCH, BIT_HIGH, BIT_LOW, DONE}
  - SNES_BITS=16
  - ID_MASK=16'hF000
  - snes_encoder also imports these indices.
- One sub-module, sync_2ff: the generic 2-flop synchronizer for snes_data_i, reused for ir_in and kb_in elsewhere.
- Counters and the FSM stay in snes_controller_reader.

Test Plan:
- Reset held, then released → latch=0, clk=1, buttons=0, valid=0, present=0; first latch rise exactly POLL_CYCLES cycles after release (POLL_CYCLES=300 in bench).
- Behavioural pad model (shift register loaded by latch, shifts on clk rise) with B and Start pressed, raw=16'hFFF6 → latch width 12; 16 clk low pulses of 6 cycles; valid single pulse 204 cycles after latch rise; buttons=16'h0009, present=1.
- snes_data_i tied 0 (unplugged) → buttons=16'hFFFF, present=0, valid still pulses once per frame.
- enable=0 for 3 poll periods → no latch/clk activity, valid never asserts, buttons hold prior value 16'h0009.
- reset_n asserted during BIT_HIGH of idx 7 → latch=0, clk=1, buttons=0 immediately; after release the next frame starts at bit 0 and publishes a correct full word.
- Consecutive frames: A pressed (raw=16'hFEFF), then R (raw=16'hF7FF) → buttons 16'h0100 then 16'h0800; exactly one valid per POLL_CYCLES interval.
